// File: rtl/mult_share_arb_pkg.sv
// Shared types and widths for the two-requester shared-multiplier arbiter.
package mult_share_arb_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        STAGE = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_share_arb_if.sv
// Request/response bundle between two requesters, the arbiter and one consumer.
interface mult_share_arb_if;
    import mult_share_arb_pkg::*;

    logic              req0_valid;
    logic              req1_valid;
    logic [OP_W-1:0]   req0_a;
    logic [OP_W-1:0]   req0_b;
    logic [OP_W-1:0]   req1_a;
    logic [OP_W-1:0]   req1_b;
    logic              req0_ready;
    logic              req1_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [PROD_W-1:0] rsp_product;
    logic              busy;

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy
    );

endinterface

// File: rtl/mult_share_arb_mul.sv
// Existing combinational 4x4 unsigned multiplier shared by both requesters.
module fourBitMultiplier (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] S
);

    assign S = {4'b0000, A} * {4'b0000, B};

endmodule

// File: rtl/mult_share_arb.sv
// Two-requester arbiter in front of one shared 4x4 multiplier.
// Define MULT_SHARE_ARB_STAGE_EN to add a pipeline stage after the multiplier.
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    mult_share_arb_if.slave bus
);

    state_t            state, state_nxt;
    logic              grant0, grant1, accept;
    logic              last_grant;
    logic [OP_W-1:0]   op_a, op_b;
    logic              op_id;
    logic [PROD_W-1:0] mul_s;
    logic [PROD_W-1:0] rsp_product_q;
    logic              rsp_id_q;
`ifdef MULT_SHARE_ARB_STAGE_EN
    logic [PROD_W-1:0] stage_product;
    logic              stage_id;
`endif

    fourBitMultiplier u_mul (
        .A (op_a),
        .B (op_b),
        .S (mul_s)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (PRIO_MODE != 0) begin
                grant0 = bus.req0_valid;
                grant1 = !bus.req0_valid && bus.req1_valid;
            end else if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept = grant0 | grant1;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
`ifdef MULT_SHARE_ARB_STAGE_EN
            CALC:  state_nxt = STAGE;
            STAGE: state_nxt = RESP;
`else
            CALC:  state_nxt = RESP;
`endif
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready  = grant0;
        bus.req1_ready  = grant1;
        bus.rsp_valid   = (state == RESP);
        bus.busy        = (state != IDLE);
        bus.rsp_product = rsp_product_q;
        bus.rsp_id      = rsp_id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant    <= 1'b1;
            op_a          <= '0;
            op_b          <= '0;
            op_id         <= 1'b0;
            rsp_product_q <= '0;
            rsp_id_q      <= 1'b0;
`ifdef MULT_SHARE_ARB_STAGE_EN
            stage_product <= '0;
            stage_id      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_a       <= grant1 ? bus.req1_a : bus.req0_a;
                op_b       <= grant1 ? bus.req1_b : bus.req0_b;
                op_id      <= grant1;
                last_grant <= grant1;
            end
`ifdef MULT_SHARE_ARB_STAGE_EN
            if (state == CALC) begin
                stage_product <= mul_s;
                stage_id      <= op_id;
            end
            if (state == STAGE) begin
                rsp_product_q <= stage_product;
                rsp_id_q      <= stage_id;
            end
`else
            if (state == CALC) begin
                rsp_product_q <= mul_s;
                rsp_id_q      <= op_id;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench: round-robin and fixed-priority instances share one stimulus.
module tb_mult_share_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0v = 1'b0, r1v = 1'b0, rsp_rdy = 1'b1;
    logic [3:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_share_arb_if bus_rr ();
    mult_share_arb_if bus_fp ();

    assign bus_rr.req0_valid = r0v;  assign bus_fp.req0_valid = r0v;
    assign bus_rr.req1_valid = r1v;  assign bus_fp.req1_valid = r1v;
    assign bus_rr.req0_a     = r0a;  assign bus_fp.req0_a     = r0a;
    assign bus_rr.req0_b     = r0b;  assign bus_fp.req0_b     = r0b;
    assign bus_rr.req1_a     = r1a;  assign bus_fp.req1_a     = r1a;
    assign bus_rr.req1_b     = r1b;  assign bus_fp.req1_b     = r1b;
    assign bus_rr.rsp_ready  = rsp_rdy;
    assign bus_fp.rsp_ready  = rsp_rdy;

    mult_share_arb #(.PRIO_MODE(0)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    mult_share_arb #(.PRIO_MODE(1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

    typedef struct {
        string      name;
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0v = 1'b1;
        r1v = 1'b1;
        @(negedge clk); #1;
        check("rst_ready0", bus_rr.req0_ready, 0);
        check("rst_ready1", bus_rr.req1_ready, 0);
        check("rst_ready0_fp", bus_fp.req0_ready, 0);
        @(negedge clk);
        r0v = 1'b0;
        r1v = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", bus_rr.rsp_valid, 0);
        check("rst_product", bus_rr.rsp_product, 0);
        check("rst_id", bus_rr.rsp_id, 0);
        check("rst_busy", bus_rr.busy, 0);
    endtask

    // One uncontended transaction on the round-robin instance with exact latency.
    task automatic do_txn(input string name, input logic id, input logic [3:0] a,
                          input logic [3:0] b, input logic [7:0] exp);
        @(negedge clk);
        if (id) begin r1a = a; r1b = b; r1v = 1'b1; end
        else    begin r0a = a; r0b = b; r0v = 1'b1; end
        #1;
        check({name, "_ready"}, id ? bus_rr.req1_ready : bus_rr.req0_ready, 1);
        check({name, "_other_ready"}, id ? bus_rr.req0_ready : bus_rr.req1_ready, 0);
        @(negedge clk);
        r0v = 1'b0;
        r1v = 1'b0;
        #1;
        check({name, "_busy"}, bus_rr.busy, 1);
        check({name, "_early_t1"}, bus_rr.rsp_valid, 0);
`ifdef MULT_SHARE_ARB_STAGE_EN
        @(negedge clk); #1;
        check({name, "_early_t2"}, bus_rr.rsp_valid, 0);
`endif
        @(negedge clk); #1;
        check({name, "_rsp_valid"}, bus_rr.rsp_valid, 1);
        check({name, "_product"}, bus_rr.rsp_product, exp);
        check({name, "_id"}, bus_rr.rsp_id, id);
        @(negedge clk); #1;
        check({name, "_done_valid"}, bus_rr.rsp_valid, 0);
        check({name, "_done_busy"}, bus_rr.busy, 0);
    endtask

    initial begin
        logic       rr_ids[4], fp_ids[4];
        logic [7:0] rr_prod[4], fp_prod[4];
        int         got_rr, got_fp, both_hi, wait_cnt, stray;

        vecs[0] = '{"v10x5",   1'b0, 4'd10, 4'd5,  8'd50};
        vecs[1] = '{"v15x15",  1'b1, 4'd15, 4'd15, 8'd225};
        vecs[2] = '{"v0x9",    1'b0, 4'd0,  4'd9,  8'd0};
        vecs[3] = '{"v11x13",  1'b0, 4'd11, 4'd13, 8'd143};
        vecs[4] = '{"v1x15",   1'b1, 4'd1,  4'd15, 8'd15};
        vecs[5] = '{"v7x9",    1'b1, 4'd7,  4'd9,  8'd63};

        do_reset();

        for (int i = 0; i < 6; i++)
            do_txn(vecs[i].name, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Contention from reset: both held valid, four responses per instance.
        do_reset();
        @(negedge clk);
        r0a = 4'd13; r0b = 4'd8; r1a = 4'd4; r1b = 4'd12;
        r0v = 1'b1;  r1v = 1'b1;
        got_rr = 0; got_fp = 0; both_hi = 0;
        for (int cyc = 0; cyc < 60 && (got_rr < 4 || got_fp < 4); cyc++) begin
            #1;
            if (cyc == 0) begin
                check("cont_first_r0_ready", bus_rr.req0_ready, 1);
                check("cont_first_r1_ready", bus_rr.req1_ready, 0);
            end
            if ((bus_rr.req0_ready && bus_rr.req1_ready) || (bus_fp.req0_ready && bus_fp.req1_ready))
                both_hi++;
            if (bus_rr.rsp_valid && got_rr < 4) begin
                rr_ids[got_rr] = bus_rr.rsp_id; rr_prod[got_rr] = bus_rr.rsp_product; got_rr++;
            end
            if (bus_fp.rsp_valid && got_fp < 4) begin
                fp_ids[got_fp] = bus_fp.rsp_id; fp_prod[got_fp] = bus_fp.rsp_product; got_fp++;
            end
            @(negedge clk);
        end
        r0v = 1'b0;
        r1v = 1'b0;
        check("cont_rr_count", got_rr, 4);
        check("cont_fp_count", got_fp, 4);
        check("cont_both_ready", both_hi, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_id%0d", i), rr_ids[i], (i % 2 == 1) ? 1 : 0);
            check($sformatf("rr_prod%0d", i), rr_prod[i], (i % 2 == 1) ? 48 : 104);
            check($sformatf("fp_id%0d", i), fp_ids[i], 0);
            check($sformatf("fp_prod%0d", i), fp_prod[i], 104);
        end

        // Backpressure: response held for five cycles, req1 waits for the bubble.
        do_reset();
        rsp_rdy = 1'b0;
        @(negedge clk);
        r0a = 4'd15; r0b = 4'd14; r0v = 1'b1;
        #1;
        check("bp_ready0", bus_rr.req0_ready, 1);
        @(negedge clk);
        r0v = 1'b0;
        #1;
        wait_cnt = 0;
        while (!bus_rr.rsp_valid && wait_cnt < 10) begin
            @(negedge clk); #1;
            wait_cnt++;
        end
        check("bp_arrive", bus_rr.rsp_valid, 1);
        r1a = 4'd3; r1b = 4'd4; r1v = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid_c%0d", i), bus_rr.rsp_valid, 1);
            check($sformatf("bp_product_c%0d", i), bus_rr.rsp_product, 210);
            check($sformatf("bp_busy_c%0d", i), bus_rr.busy, 1);
            check($sformatf("bp_r1_ready_c%0d", i), bus_rr.req1_ready, 0);
            @(negedge clk); #1;
        end
        rsp_rdy = 1'b1;
        #1;
        check("bp_hs_valid", bus_rr.rsp_valid, 1);
        check("bp_hs_r1_ready", bus_rr.req1_ready, 0);
        @(negedge clk); #1;
        check("bp_bubble_valid", bus_rr.rsp_valid, 0);
        check("bp_bubble_r1_ready", bus_rr.req1_ready, 1);
        @(negedge clk);
        r1v = 1'b0;
        #1;
`ifdef MULT_SHARE_ARB_STAGE_EN
        @(negedge clk); #1;
`endif
        @(negedge clk); #1;
        check("bp_r1_valid", bus_rr.rsp_valid, 1);
        check("bp_r1_product", bus_rr.rsp_product, 12);
        check("bp_r1_id", bus_rr.rsp_id, 1);
        @(negedge clk); #1;

        // Reset in CALC discards the transaction.
        @(negedge clk);
        r0a = 4'd6; r0b = 4'd10; r0v = 1'b1;
        #1;
        check("mr_ready0", bus_rr.req0_ready, 1);
        @(negedge clk);
        r0v = 1'b0;
        rst = 1'b1;
        #1;
        check("mr_calc_busy", bus_rr.busy, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_valid", bus_rr.rsp_valid, 0);
        check("mr_product", bus_rr.rsp_product, 0);
        check("mr_id", bus_rr.rsp_id, 0);
        check("mr_busy", bus_rr.busy, 0);
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_rr.rsp_valid || bus_rr.busy) stray++;
            @(negedge clk); #1;
        end
        check("mr_no_response", stray, 0);
        do_txn("post_rst_3x3", 1'b1, 4'd3, 4'd3, 8'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 SHALL have parameter: PRIO_MODE, 0, arbitration policy (0 = round-robin, 1 = fixed priority, requester 0 wins).
REQ-002 SHALL have port: clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1  each requester has an operand pair pending.
REQ-005 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  4  unsigned operands.
REQ-006 SHALL have ports: req0_ready, req1_ready  output  1  operand pair accepted this cycle.
REQ-007 SHALL have port: rsp_valid  output  1  result available.
REQ-008 SHALL have port: rsp_ready  input  1  consumer takes the result.
REQ-009 SHALL have port: rsp_id  output  1  index of the requester that owns the result.
REQ-010 SHALL have port: rsp_product  output  8  unsigned product a*b.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC, STAGE (present only with the macro), and RESP.
REQ-013 In IDLE, if any reqN_valid is high, SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, capture its a, b and id, and go to CALC.
REQ-014 SHALL assert reqN_ready only in IDLE, and only for the granted requester.
REQ-015 Round-robin: when both requesters are valid, SHALL grant the one not granted last.
REQ-016 last_grant SHALL reset to 1, so requester 0 wins the first contention.
REQ-017 last_grant SHALL update only on an accepted grant.
REQ-018 Fixed priority: requester 0 SHALL win whenever req0_valid is high.
REQ-019 In CALC, SHALL present the captured operands to the shared multiplier and register its 8-bit output.
REQ-020 Without the macro, CALC SHALL go to RESP.
REQ-021 In RESP, SHALL hold rsp_valid high with rsp_product and rsp_id stable until rsp_ready is high, then go to IDLE.
REQ-022 Latency: accept at cycle T gives rsp_valid at T+2 without the macro and T+3 with it.
REQ-023 A request presented in the same cycle as the RESP handshake SHALL NOT be accepted; it is accepted in the following IDLE cycle (one-cycle bubble).
REQ-024 The product SHALL be the full 8-bit value, with no truncation; 15*15 = 225.
REQ-025 Requester inputs SHALL be ignored outside IDLE.
REQ-026 A requester dropping valid before it is granted SHALL lose nothing and SHALL NOT be granted.

Reset
REQ-027 On rst high at a clock edge: state = IDLE, rsp_valid = 0, rsp_product = 0x00, rsp_id = 0, last_grant = 1, req0_ready = req1_ready = 0, busy = 0.
REQ-028 Reset mid-transaction (CALC, STAGE or RESP) SHALL discard the transaction with no response.
REQ-029 reqN_ready SHALL be low while rst is high.

Configuration
REQ-030 Macro MULT_SHARE_ARB_STAGE_EN defined: the STAGE state SHALL add a pipeline register between the multiplier output and the rsp registers, giving latency T+3.
REQ-031 Macro MULT_SHARE_ARB_STAGE_EN undefined: STAGE and its register SHALL NOT exist, giving latency T+2.
REQ-032 Handshake behaviour other than latency SHALL be identical with and without the macro.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, CALC, STAGE, RESP), the operand width constant (4), and the product width constant (8).
REQ-034 SHALL instantiate the existing fourBitMultiplier (A[3:0], B[3:0] -> S[7:0]) exactly once as its only sub-module.
REQ-035 SHALL contain no other arithmetic.

Verification
REQ-036 Single request: req0 a=10, b=5 valid at T -> req0_ready=1 at T; rsp_valid=1 at T+2 with rsp_product=50 and rsp_id=0.
REQ-037 Contention after reset: req0 13x8 and req1 4x12 both held valid -> first response 104 with id 0, second response 48 with id 1; req1_ready is never high while req0 is granted.
REQ-038 Round-robin alternation: both requesters continuously valid for 4 transactions -> rsp_id sequence 0,1,0,1; with PRIO_MODE=1 -> sequence 0,0,0,0.
REQ-039 Backpressure: 15x14 with rsp_ready low for 5 cycles -> rsp_valid stays high and rsp_product stays 210 throughout; busy=1; new requests are not accepted until the cycle after the handshake.
REQ-040 Reset mid-CALC: rst pulsed in CALC of a 6x10 transaction -> no rsp_valid, all outputs at their reset values; the next req1 3x3 returns 9 with id 1.
REQ-041 Macro on versus off: the same 11x13 stimulus -> rsp_product=143, with rsp_valid at T+3 and T+2 respectively.
